// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of the single data-memory port.
// Enforces the DM address window: out-of-range writes dropped, reads return ones.
module dm_port_arbiter #(
   parameter int unsigned RD_LAT     = 1,
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_00FF
) (
   input  logic        CLK,
   input  logic        Z_R,
   input  logic        P0_REQ,
   input  logic        P1_REQ,
   input  logic        P0_WE,
   input  logic        P1_WE,
   input  logic [31:0] P0_ADDR,
   input  logic [31:0] P1_ADDR,
   input  logic [31:0] P0_WR_DATA,
   input  logic [31:0] P1_WR_DATA,
   output logic        P0_GNT,
   output logic        P1_GNT,
   output logic        P0_RD_VALID,
   output logic        P1_RD_VALID,
   output logic [31:0] P0_RD_DATA,
   output logic [31:0] P1_RD_DATA,
   output logic        ERR,
   output logic        BUSY,
   output logic        DM_WE,
   output logic [31:0] DM_ADDR,
   output logic [31:0] DM_WR_DATA,
   input  logic [31:0] DM_RD_DATA
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_RDWAIT = 2'd2
   } state_t;

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_t      r_state;
   logic        r_prio;
   logic        r_port;
   logic        r_we;
   logic        r_oor;
   logic [2:0]  r_cnt;
   logic        r_gnt0;
   logic        r_gnt1;
   logic        r_rv0;
   logic        r_rv1;
   logic        r_err;
   logic        r_dm_we;
   logic [31:0] r_dm_addr;
   logic [31:0] r_dm_wdata;
   logic [31:0] r_rd0;
   logic [31:0] r_rd1;

   logic        w_any;
   logic        w_pick1;
   logic        w_we;
   logic        w_oor;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [31:0] w_rdata;

   assign w_any   = P0_REQ | P1_REQ;
   assign w_pick1 = P1_REQ & (~P0_REQ | r_prio);
   assign w_we    = w_pick1 ? P1_WE : P0_WE;
   assign w_addr  = w_pick1 ? P1_ADDR : P0_ADDR;
   assign w_wdata = w_pick1 ? P1_WR_DATA : P0_WR_DATA;
   assign w_oor   = w_addr > ADDR_LIMIT;
   assign w_rdata = r_oor ? 32'hFFFF_FFFF : DM_RD_DATA;

   always_ff @(posedge CLK) begin
      if (Z_R) begin
         r_state    <= S_IDLE;
         r_prio     <= 1'b0;
         r_port     <= 1'b0;
         r_we       <= 1'b0;
         r_oor      <= 1'b0;
         r_cnt      <= 3'd0;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_rv0      <= 1'b0;
         r_rv1      <= 1'b0;
         r_err      <= 1'b0;
         r_dm_we    <= 1'b0;
         r_dm_addr  <= 32'd0;
         r_dm_wdata <= 32'd0;
         r_rd0      <= 32'd0;
         r_rd1      <= 32'd0;
      end else begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_rv0   <= 1'b0;
         r_rv1   <= 1'b0;
         r_err   <= 1'b0;
         r_dm_we <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  // Grant outputs are registered here so they show in ISSUE
                  r_port     <= w_pick1;
                  r_we       <= w_we;
                  r_oor      <= w_oor;
                  r_dm_addr  <= w_addr;
                  r_dm_wdata <= w_wdata;
                  r_dm_we    <= w_we & ~w_oor;
                  r_gnt0     <= ~w_pick1;
                  r_gnt1     <= w_pick1;
                  r_err      <= w_oor;
                  r_prio     <= ~w_pick1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_we) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt   <= LAT;
                  r_state <= S_RDWAIT;
               end
            end
            S_RDWAIT: begin
               if (r_cnt <= 3'd1) begin
                  r_cnt   <= 3'd0;
                  r_state <= S_IDLE;
                  if (r_port) begin
                     r_rd1 <= w_rdata;
                     r_rv1 <= 1'b1;
                  end else begin
                     r_rd0 <= w_rdata;
                     r_rv0 <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign P0_GNT      = r_gnt0;
   assign P1_GNT      = r_gnt1;
   assign P0_RD_VALID = r_rv0;
   assign P1_RD_VALID = r_rv1;
   assign P0_RD_DATA  = r_rd0;
   assign P1_RD_DATA  = r_rd1;
   assign ERR         = r_err;
   assign BUSY        = (r_state != S_IDLE);
   // Reset kills a write strobe in the very cycle it is raised
   assign DM_WE       = r_dm_we & ~Z_R;
   assign DM_ADDR     = r_dm_addr;
   assign DM_WR_DATA  = r_dm_wdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: four instances with RD_LAT 1..4, each with
// its own latency-accurate memory, driven by table, hand and random tests.
module tb_dm_port_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_init = 1'b1;
   always #5 clk = ~clk;

   logic        p0_req[N], p1_req[N], p0_we[N], p1_we[N];
   logic [31:0] p0_addr[N], p1_addr[N], p0_wd[N], p1_wd[N];
   logic        gnt0[N], gnt1[N], rv0[N], rv1[N], err[N], busy[N], dm_we[N];
   logic [31:0] rd0[N], rd1[N], dm_addr[N], dm_wd[N], dm_rd[N];

   int checks = 0;
   int errors = 0;
   logic [31:0] rmem[N][64];

   function automatic logic [31:0] init_word(int g, int i);
      return 32'h5A00_0000 ^ (32'(g) << 16) ^ (32'(i) * 32'h0000_0101);
   endfunction

   for (genvar g = 0; g < N; g++) begin : gen
      logic [31:0] mem[64];
      logic [31:0] pipe[4];
      dm_port_arbiter #(.RD_LAT(g + 1), .ADDR_LIMIT(32'hFF)) u_dut (
         .CLK(clk), .Z_R(rst),
         .P0_REQ(p0_req[g]), .P1_REQ(p1_req[g]),
         .P0_WE(p0_we[g]), .P1_WE(p1_we[g]),
         .P0_ADDR(p0_addr[g]), .P1_ADDR(p1_addr[g]),
         .P0_WR_DATA(p0_wd[g]), .P1_WR_DATA(p1_wd[g]),
         .P0_GNT(gnt0[g]), .P1_GNT(gnt1[g]),
         .P0_RD_VALID(rv0[g]), .P1_RD_VALID(rv1[g]),
         .P0_RD_DATA(rd0[g]), .P1_RD_DATA(rd1[g]),
         .ERR(err[g]), .BUSY(busy[g]),
         .DM_WE(dm_we[g]), .DM_ADDR(dm_addr[g]),
         .DM_WR_DATA(dm_wd[g]), .DM_RD_DATA(dm_rd[g])
      );
      // Memory with g+1 cycles from address to data
      always @(posedge clk) begin
         if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(g, i);
         end else if (dm_we[g]) begin
            mem[dm_addr[g][7:2]] <= dm_wd[g];
         end
         pipe[0] <= mem[dm_addr[g][7:2]];
         for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
      end
      assign dm_rd[g] = pipe[g];
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_port(int k, bit p, bit r, bit we,
                           logic [31:0] a, logic [31:0] d);
      if (p) begin
         p1_req[k] = r; p1_we[k] = we; p1_addr[k] = a; p1_wd[k] = d;
      end else begin
         p0_req[k] = r; p0_we[k] = we; p0_addr[k] = a; p0_wd[k] = d;
      end
   endtask

   task automatic drop(int k, bit p);
      if (p) p1_req[k] = 1'b0;
      else p0_req[k] = 1'b0;
   endtask

   task automatic clear_all();
      for (int k = 0; k < N; k++) begin
         set_port(k, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
         set_port(k, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      end
   endtask

   task automatic do_reset();
      clear_all();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      int s;
      s = int'($urandom_range(0, 9));
      if (s == 0) return 32'h100 + 32'($urandom_range(0, 255));
      if (s == 1) return $urandom;
      if (s == 2) return 32'hFF;
      return 32'($urandom_range(0, 63)) * 4;
   endfunction

   // One isolated transaction; latencies count negedges after raising REQ
   task automatic txn(int k, bit p, bit we, logic [31:0] a, logic [31:0] d,
                      output int glat, output int wecnt, output bit e,
                      output logic [31:0] wa, output int rlat,
                      output logic [31:0] rdat);
      glat = 0; wecnt = 0; e = 1'b0; wa = '0; rlat = 0; rdat = '0;
      set_port(k, p, 1'b1, we, a, d);
      if (we && a <= 32'hFF) rmem[k][a[7:2]] = d;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if ((p ? gnt1[k] : gnt0[k]) && glat == 0) begin
            glat = n;
            drop(k, p);
         end
         if (dm_we[k]) begin
            wecnt++;
            wa = dm_addr[k];
         end
         if (err[k]) e = 1'b1;
         if (p ? rv1[k] : rv0[k]) begin
            rlat = n;
            rdat = p ? rd1[k] : rd0[k];
         end
         if (glat != 0 && n >= glat + (we ? 1 : k + 2)) break;
      end
      drop(k, p);
   endtask

   typedef struct {
      bit          p;
      bit          we;
      logic [31:0] a;
      logic [31:0] d;
      bit          e;
      int          wecnt;
      logic [31:0] rdat;
   } vec_t;

   task automatic run_random(int k, int ncyc);
      int next_arb, busy_end;
      int rv_at[2];
      logic [31:0] rv_val[2], hold[2];
      bit prio, w, oor, ee, ewe;
      bit eg[2];
      logic [31:0] last_a, last_d, a, d;
      bit r, we;
      prio = 1'b0; last_a = '0; last_d = '0;
      hold[0] = '0; hold[1] = '0;
      rv_at[0] = -1; rv_at[1] = -1;
      next_arb = 0; busy_end = -1;
      for (int c = 1; c <= ncyc; c++) begin
         for (int p = 0; p < 2; p++) begin
            r = (p == 1) ? p1_req[k] : p0_req[k];
            if (r) begin
               if ($urandom_range(0, 24) == 0) drop(k, p == 1);
            end else if ($urandom_range(0, 2) == 0) begin
               set_port(k, p == 1, 1'b1, 1'($urandom_range(0, 1)),
                        rnd_addr(), $urandom);
            end
         end
         eg[0] = 1'b0; eg[1] = 1'b0; ee = 1'b0; ewe = 1'b0;
         if (c >= next_arb && (p0_req[k] || p1_req[k])) begin
            w    = (p0_req[k] && p1_req[k]) ? prio : p1_req[k];
            prio = !w;
            a    = w ? p1_addr[k] : p0_addr[k];
            d    = w ? p1_wd[k] : p0_wd[k];
            we   = w ? p1_we[k] : p0_we[k];
            oor  = a > 32'hFF;
            eg[w] = 1'b1;
            ee   = oor;
            ewe  = we && !oor;
            last_a = a;
            last_d = d;
            if (we) begin
               if (!oor) rmem[k][a[7:2]] = d;
               next_arb = c + 2;
               busy_end = c;
            end else begin
               rv_at[w]  = c + k + 2;
               rv_val[w] = oor ? 32'hFFFF_FFFF : rmem[k][a[7:2]];
               next_arb  = c + k + 3;
               busy_end  = c + k + 1;
            end
         end
         @(negedge clk);
         if (rv_at[0] == c) hold[0] = rv_val[0];
         if (rv_at[1] == c) hold[1] = rv_val[1];
         chk($sformatf("rnd%0d_ctl c%0d", k, c),
             32'({gnt0[k], gnt1[k], err[k], dm_we[k], busy[k], rv0[k], rv1[k]}),
             32'({eg[0], eg[1], ee, ewe, c <= busy_end,
                  rv_at[0] == c, rv_at[1] == c}));
         chk($sformatf("rnd%0d_addr c%0d", k, c), dm_addr[k], last_a);
         chk($sformatf("rnd%0d_wd c%0d", k, c), dm_wd[k], last_d);
         chk($sformatf("rnd%0d_rd0 c%0d", k, c), rd0[k], hold[0]);
         chk($sformatf("rnd%0d_rd1 c%0d", k, c), rd1[k], hold[1]);
         if (gnt0[k]) drop(k, 1'b0);
         if (gnt1[k]) drop(k, 1'b1);
      end
      clear_all();
      repeat (8) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tv[11];
      int glat, wecnt, rlat, seen, ne;
      bit e;
      logic [31:0] wa, rdat, d;
      logic [31:0] ev_a[16], ev_d[16];
      int ev_c[16];
      int i0, i1, pe, ie;

      tv[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 1, 32'h0};
      tv[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 0, 32'hDEADBEEF};
      tv[2]  = '{1'b1, 1'b1, 32'h100,      32'h13572468, 1'b1, 0, 32'h0};
      tv[3]  = '{1'b1, 1'b0, 32'h104,      32'h0,        1'b1, 0, 32'hFFFFFFFF};
      tv[4]  = '{1'b1, 1'b1, 32'hFC,       32'h12345678, 1'b0, 1, 32'h0};
      tv[5]  = '{1'b0, 1'b0, 32'hFF,       32'h0,        1'b0, 0, 32'h12345678};
      tv[6]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b1, 0, 32'h0};
      tv[7]  = '{1'b1, 1'b0, 32'h100,      32'h0,        1'b1, 0, 32'hFFFFFFFF};
      tv[8]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 0, 32'hDEADBEEF};
      tv[9]  = '{1'b0, 1'b1, 32'h13,       32'h0BADF00D, 1'b0, 1, 32'h0};
      tv[10] = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 0, 32'h0BADF00D};

      for (int k = 0; k < N; k++)
         for (int i = 0; i < 64; i++) rmem[k][i] = init_word(k, i);
      clear_all();

      // Reset held two cycles with both requests up
      set_port(0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h1111_1111);
      set_port(0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h2222_2222);
      repeat (2) begin
         @(negedge clk);
         tb_init = 1'b0;
         chk("rst_ctl", 32'({gnt0[0], gnt1[0], rv0[0], rv1[0],
                             err[0], busy[0], dm_we[0]}), 32'd0);
         chk("rst_addr", dm_addr[0], 32'd0);
         chk("rst_wd", dm_wd[0], 32'd0);
         chk("rst_rd0", rd0[0], 32'd0);
         chk("rst_rd1", rd1[0], 32'd0);
      end
      rst = 1'b0;
      rmem[0][16] = 32'h1111_1111;
      rmem[0][17] = 32'h2222_2222;
      @(negedge clk);
      chk("rst_first_gnt", 32'({gnt0[0], gnt1[0]}), 32'b10);
      drop(0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_second_gnt", 32'({gnt0[0], gnt1[0]}), 32'b01);
      drop(0, 1'b1);
      @(negedge clk);

      // Table of single transactions on the RD_LAT=1 instance
      for (int i = 0; i < 11; i++) begin
         txn(0, tv[i].p, tv[i].we, tv[i].a, tv[i].d,
             glat, wecnt, e, wa, rlat, rdat);
         chk($sformatf("tv%0d_glat", i), glat, 1);
         chk($sformatf("tv%0d_we", i), wecnt, tv[i].wecnt);
         chk($sformatf("tv%0d_err", i), 32'(e), 32'(tv[i].e));
         if (tv[i].wecnt > 0) chk($sformatf("tv%0d_addr", i), wa, tv[i].a);
         if (!tv[i].we) begin
            chk($sformatf("tv%0d_rlat", i), rlat, 3);
            chk($sformatf("tv%0d_rdat", i), rdat, tv[i].rdat);
         end
      end

      // Continuous contention: eight writes alternate starting with P0
      do_reset();
      i0 = 0; i1 = 0; ne = 0;
      set_port(0, 1'b0, 1'b1, 1'b1, 32'h80, 32'hA000_0000);
      set_port(0, 1'b1, 1'b1, 1'b1, 32'h84, 32'hB000_0000);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (dm_we[0] && ne < 16) begin
            ev_a[ne] = dm_addr[0]; ev_d[ne] = dm_wd[0]; ev_c[ne] = n; ne++;
         end
         if (gnt0[0]) begin
            i0++;
            if (i0 < 4)
               set_port(0, 1'b0, 1'b1, 1'b1, 32'h80 + 32'(8 * i0),
                        32'hA000_0000 + 32'(i0));
            else drop(0, 1'b0);
         end
         if (gnt1[0]) begin
            i1++;
            if (i1 < 4)
               set_port(0, 1'b1, 1'b1, 1'b1, 32'h84 + 32'(8 * i1),
                        32'hB000_0000 + 32'(i1));
            else drop(0, 1'b1);
         end
         if (i0 >= 4 && i1 >= 4 && n > ev_c[ne > 0 ? ne - 1 : 0] + 2) break;
      end
      chk("cont_count", ne, 8);
      for (int j = 0; j < ne && j < 8; j++) begin
         pe = j % 2;
         ie = j / 2;
         chk($sformatf("cont%0d_addr", j), ev_a[j],
             (pe == 1 ? 32'h84 : 32'h80) + 32'(8 * ie));
         chk($sformatf("cont%0d_data", j), ev_d[j],
             (pe == 1 ? 32'hB000_0000 : 32'hA000_0000) + 32'(ie));
         if (j > 0) chk($sformatf("cont%0d_gap", j), ev_c[j] - ev_c[j-1], 2);
         rmem[0][ev_a[j][7:2]] = ev_d[j];
      end
      clear_all();
      @(negedge clk);

      // Reset mid-read on the RD_LAT=3 instance
      do_reset();
      set_port(2, 1'b1, 1'b1, 1'b0, 32'h08, 32'd0);
      @(negedge clk);
      chk("mid_gnt", 32'(gnt1[2]), 32'd1);
      drop(2, 1'b1);
      @(negedge clk);
      chk("mid_busy_wait", 32'(busy[2]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_after", 32'({busy[2], rv1[2], rv0[2]}), 32'd0);
      chk("mid_rd1", rd1[2], 32'd0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rv1[2] || rv0[2]) seen++;
      end
      chk("mid_no_rv", seen, 0);
      set_port(2, 1'b0, 1'b1, 1'b1, 32'h30, 32'h3030_3030);
      set_port(2, 1'b1, 1'b1, 1'b1, 32'h34, 32'h3434_3434);
      rmem[2][12] = 32'h3030_3030;
      rmem[2][13] = 32'h3434_3434;
      @(negedge clk);
      chk("mid_next_p0", 32'({gnt0[2], gnt1[2]}), 32'b10);
      drop(2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("mid_next_p1", 32'({gnt0[2], gnt1[2]}), 32'b01);
      drop(2, 1'b1);
      @(negedge clk);

      // Reset raised during a write's ISSUE cycle suppresses the strobe
      do_reset();
      set_port(0, 1'b0, 1'b1, 1'b1, 32'h50, 32'h7777_7777);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("rstwe_gate", 32'(dm_we[0]), 32'd0);
      @(negedge clk);
      drop(0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      chk("rstwe_after", 32'({dm_we[0], gnt0[0], busy[0]}), 32'd0);
      @(negedge clk);
      chk("rstwe_mem", gen[0].mem[20], rmem[0][20]);

      // Latency sweep across all four instances
      for (int k = 0; k < N; k++) begin
         d = $urandom;
         txn(k, 1'(k % 2), 1'b1, 32'(4 * (k + 5)), d,
             glat, wecnt, e, wa, rlat, rdat);
         chk($sformatf("lat%0d_wr", k), wecnt, 1);
         txn(k, 1'((k + 1) % 2), 1'b0, 32'(4 * (k + 5)), 32'd0,
             glat, wecnt, e, wa, rlat, rdat);
         chk($sformatf("lat%0d_glat", k), glat, 1);
         chk($sformatf("lat%0d_rlat", k), rlat, k + 3);
         chk($sformatf("lat%0d_rdat", k), rdat, d);
      end

      // Randomized traffic against the transaction-level model
      for (int k = 0; k < N; k++) begin
         do_reset();
         run_random(k, 300);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the single data-memory port (DM_WE / DM_ADDR / DM_WR_DATA / DM_RD_DATA) between two requesters:

- Port 0: the `mips` core.
- Port 1: a loader/debug master that fills or inspects data memory.

Requesters are served one transaction at a time with round-robin priority. The block sits between the core's DM interface and the memory model/array. It also enforces the data-memory address window: out-of-range reads return all-ones and out-of-range writes are dropped.

## Interface

Parameters:
- `RD_LAT`, 1 — cycles from DM_ADDR issue to valid DM_RD_DATA (1..4).
- `ADDR_LIMIT`, 32'h0000_00FF — highest legal byte address; above this is out of range.

Ports:
- `CLK` in 1 — single clock; all state on rising edge.
- `Z_R` in 1 — reset; synchronous, active-high.
- `P0_REQ`, `P1_REQ` in 1 — transaction request; held until the matching GNT.
- `P0_WE`, `P1_WE` in 1 — 1 = write, 0 = read; stable while REQ.
- `P0_ADDR`, `P1_ADDR` in 32 — byte address; stable while REQ.
- `P0_WR_DATA`, `P1_WR_DATA` in 32 — write data; stable while REQ.
- `P0_GNT`, `P1_GNT` out 1 — one-cycle pulse: transaction accepted and issued.
- `P0_RD_VALID`, `P1_RD_VALID` out 1 — one-cycle pulse: read data valid.
- `P0_RD_DATA`, `P1_RD_DATA` out 32 — read data; held until the next RD_VALID for that port.
- `ERR` out 1 — one-cycle pulse, in the GNT cycle, when the issued address exceeds ADDR_LIMIT.
- `BUSY` out 1 — high whenever state is not IDLE.
- `DM_WE` out 1 — memory write enable.
- `DM_ADDR` out 32 — memory byte address.
- `DM_WR_DATA` out 32 — memory write data.
- `DM_RD_DATA` in 32 — memory read data.

## Operation

States: IDLE, ISSUE, RDWAIT.

**IDLE**
- If any REQ is high, select a winner:
  - Only one requester: grant that one.
  - Both requesters: grant port PRIO.
- Latch the winner's WE/ADDR/WR_DATA and port id.
- Set PRIO to the other port, regardless of contention.
- Go to ISSUE.
- If no REQ is high, stay in IDLE.

**ISSUE** (exactly one cycle)
- Drive DM_ADDR and DM_WR_DATA from the latched values.
- DM_WE = latched WE && in-range.
- Pulse the winner's GNT.
- Pulse ERR if out of range.
- Next state: write → IDLE; read → RDWAIT, with the counter loaded to RD_LAT.

**RDWAIT**
- Decrement the counter each cycle.
- When the counter reaches 0, capture DM_RD_DATA into the winner's RD_DATA (or 32'hFFFF_FFFF if out of range), pulse RD_VALID, and go to IDLE.

Rules:
- DM_WE is never high outside ISSUE.
- DM_ADDR and DM_WR_DATA hold their last values outside ISSUE.
- Address compare is unsigned 32-bit: `ADDR > ADDR_LIMIT`.
- Low address bits are forwarded unchanged; the memory indexes by ADDR>>2.
- REQ sampled in ISSUE/RDWAIT is ignored until return to IDLE. No queuing: a requester keeps REQ high until its GNT.
- A requester that drops REQ before GNT is simply not served. A transaction already latched still completes.
- An out-of-range read still takes the full RD_LAT wait, so latency is uniform.

Reset (Z_R high at a rising edge):
- State → IDLE; PRIO → 0.
- Counter and all latched values → 0.
- Every output → 0: DM_WE, DM_ADDR, DM_WR_DATA, GNTs, RD_VALIDs, RD_DATAs, ERR, BUSY.
- Reset mid-transaction abandons it: no GNT/RD_VALID afterwards, and no DM_WE in the reset cycle or the following cycle.

## Timing

- Request sampled in IDLE at edge t → ISSUE during cycle t+1 (GNT, DM_* driven) → edge t+2.
- Write: back in IDLE after edge t+2. Next grant's ISSUE is at t+3 at the earliest, giving 2-cycle occupancy.
- Read: RD_VALID during cycle t+1+RD_LAT+1 (with RD_LAT=1: cycle t+3). DM_RD_DATA is sampled at the edge ending cycle t+1+RD_LAT. Occupancy is 2+RD_LAT cycles.
- Continuous contention alternates P0, P1, P0, … Neither port waits more than one foreign transaction.
- GNT, RD_VALID, ERR and DM_WE are registered outputs with no combinational path from REQ.

## Test plan

- **Reset:** hold Z_R=1 for 2 cycles with both REQ high → all outputs 0, no GNT. Release → P0 granted first.
- **P0 write then read:** write ADDR=0x10, data 0xDEADBEEF → DM_WE=1 for exactly one cycle with DM_ADDR=0x10. Then read 0x10 (memory model returns 0xDEADBEEF after RD_LAT=1) → P0_RD_VALID 3 cycles after the REQ sample, P0_RD_DATA=0xDEADBEEF.
- **Contention:** both ports continuously write distinct addresses for 8 transactions → grant order P0,P1,P0,P1…, one DM_WE per 2 cycles, no lost or duplicated writes.
- **Out of range:** P1 write to 0x100 → ERR pulse, DM_WE stays 0. P1 read from 0x104 → P1_RD_DATA=0xFFFFFFFF, ERR pulse.
- **Reset mid-read:** with RD_LAT=3, assert Z_R during RDWAIT → no RD_VALID, BUSY=0 next cycle. The next request is served normally with PRIO=0.
- **Latency sweep:** RD_LAT=1..4 reads → RD_VALID exactly RD_LAT+2 cycles after the IDLE sample edge, data matches the memory model.
